// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter in front of a single UART transmitter
// Grants whole messages, sequences the byte handshake and revokes a stalled grant via a watchdog.
module uart_tx_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ-1:0]   i_stb,
    input  logic [8*NREQ-1:0] i_data,
    input  logic [NREQ-1:0]   i_last,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_tx_stb,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy,
    output logic              o_timeout
);

    localparam int PW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0]   WDOG_MAX = WW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANTED,
        S_STROBE,
        S_DRAIN,
        S_RELEASE
    } state_t;

    state_t          state;
    logic [PW-1:0]   g;
    logic [PW-1:0]   rr_ptr;
    logic [WW-1:0]   wdog;
    logic            lastf;
    logic [PW-1:0]   pick;
    logic            pick_valid;

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Walk from the farthest offset back to rr_ptr so the nearest requester wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[rr_index(rr_ptr, i)]) begin
                pick       = rr_index(rr_ptr, i);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            g         <= '0;
            rr_ptr    <= '0;
            wdog      <= '0;
            lastf     <= 1'b0;
            o_ack     <= '0;
            o_grant   <= '0;
            o_tx_stb  <= 1'b0;
            o_tx_data <= '0;
            o_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        g       <= pick;
                        o_grant <= ONE << pick;
                        wdog    <= '0;
                        state   <= S_GRANTED;
                    end
                end
                S_GRANTED: begin
                    // A dropped request aborts the message even if a byte is on offer.
                    if (!i_req[g]) begin
                        state <= S_RELEASE;
                    end else if (i_stb[g] && !i_tx_busy) begin
                        o_tx_stb  <= 1'b1;
                        o_tx_data <= i_data[int'(g)*8 +: 8];
                        o_ack     <= ONE << g;
                        lastf     <= i_last[g];
                        state     <= S_STROBE;
                    end else if (wdog == WDOG_MAX) begin
                        o_timeout <= 1'b1;
                        state     <= S_RELEASE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                S_STROBE: begin
                    o_tx_stb <= 1'b0;
                    o_ack    <= '0;
                    wdog     <= '0;
                    state    <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!i_tx_busy) state <= lastf ? S_RELEASE : S_GRANTED;
                end
                S_RELEASE: begin
                    o_grant   <= '0;
                    o_timeout <= 1'b0;
                    rr_ptr    <= rr_index(g, 1);
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
// Sources and the transmitter busy model are driven on the falling edge from one process.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [2:0]  i_req = '0;
    logic [2:0]  i_stb = '0;
    logic [23:0] i_data = '0;
    logic [2:0]  i_last = '0;
    logic        i_tx_busy = 1'b0;
    logic [2:0]  o_ack;
    logic [2:0]  o_grant;
    logic        o_tx_stb;
    logic [7:0]  o_tx_data;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    logic [8:0] srcq [NREQ][$];
    logic [2:0] drop = '0;
    logic [2:0] nostb = '0;
    logic       force_busy = 1'b0;
    int         busy_cnt = 0;
    int         busy_len = 10;
    logic [7:0] txlog [$];
    logic [2:0] grantlog [$];
    logic [2:0] prev_grant = '0;
    int         ackcnt [NREQ];
    int         tocnt = 0;
    int         n;
    int         base;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .i_stb     (i_stb),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_ack     (o_ack),
        .o_grant   (o_grant),
        .o_tx_stb  (o_tx_stb),
        .o_tx_data (o_tx_data),
        .i_tx_busy (i_tx_busy),
        .o_timeout (o_timeout)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] txat(input int i);
        if (i < txlog.size()) return 32'(txlog[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gat(input int i);
        if (i < grantlog.size()) return 32'(grantlog[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            i_req[k] = (srcq[k].size() != 0) && !drop[k];
            i_stb[k] = (srcq[k].size() != 0) && !nostb[k];
            if (srcq[k].size() != 0) begin
                i_data[8*k +: 8] = srcq[k][0][7:0];
                i_last[k]        = srcq[k][0][8];
            end else begin
                i_data[8*k +: 8] = 8'h00;
                i_last[k]        = 1'b0;
            end
        end
        i_tx_busy = force_busy || (busy_cnt != 0);
    endtask

    task automatic tick();
        @(negedge i_clk);
        if (o_tx_stb) txlog.push_back(o_tx_data);
        if (o_timeout) tocnt++;
        if (o_ack != 3'b000) check("ack_owner", 32'(o_ack & ~o_grant), 32'h0);
        for (int k = 0; k < NREQ; k++) begin
            if (o_ack[k]) begin
                ackcnt[k]++;
                if (srcq[k].size() != 0) void'(srcq[k].pop_front());
            end
        end
        if (o_grant != prev_grant && o_grant != 3'b000) grantlog.push_back(o_grant);
        prev_grant = o_grant;
        if (!i_rst_n) busy_cnt = 0;
        else if (o_tx_stb) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        drive();
    endtask

    task automatic wait_idle(input string tag);
        int m;
        m = 0;
        while ((o_grant != 3'b000 || srcq[0].size() != 0 || srcq[1].size() != 0 ||
                srcq[2].size() != 0) && m < 400) begin
            tick();
            m++;
        end
        check(tag, 32'(m < 400), 32'h1);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NREQ; k++) ackcnt[k] = 0;

        i_rst_n = 1'b0;
        repeat (3) tick();
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_ack", 32'(o_ack), 32'h0);
        check("rst_tx_stb", 32'(o_tx_stb), 32'h0);
        check("rst_tx_data", 32'(o_tx_data), 32'h0);
        check("rst_timeout", 32'(o_timeout), 32'h0);
        i_rst_n = 1'b1;
        tick();

        // three-byte message from source 0
        txlog.delete(); grantlog.delete();
        base = ackcnt[0];
        srcq[0].push_back(9'h058); srcq[0].push_back(9'h04F); srcq[0].push_back(9'h10A);
        drive();
        tick();
        check("t1_grant_lat", 32'(o_grant), 32'h1);
        tick();
        check("t1_first_stb", 32'(o_tx_stb), 32'h1);
        wait_idle("t1_done");
        check("t1_tx_count", 32'(txlog.size()), 32'd3);
        check("t1_tx0", txat(0), 32'h58);
        check("t1_tx1", txat(1), 32'h4F);
        check("t1_tx2", txat(2), 32'h0A);
        check("t1_acks", 32'(ackcnt[0] - base), 32'd3);
        check("t1_grants", 32'(grantlog.size()), 32'd1);

        // round robin over all three, then 0 and 2
        do_reset();
        txlog.delete(); grantlog.delete();
        srcq[0].push_back(9'h111); srcq[1].push_back(9'h122); srcq[2].push_back(9'h133);
        drive();
        wait_idle("t2a_done");
        check("t2a_g0", gat(0), 32'h1);
        check("t2a_g1", gat(1), 32'h2);
        check("t2a_g2", gat(2), 32'h4);
        check("t2a_tx0", txat(0), 32'h11);
        check("t2a_tx1", txat(1), 32'h22);
        check("t2a_tx2", txat(2), 32'h33);
        txlog.delete(); grantlog.delete();
        srcq[0].push_back(9'h144); srcq[2].push_back(9'h155);
        drive();
        wait_idle("t2b_done");
        check("t2b_g0", gat(0), 32'h1);
        check("t2b_g1", gat(1), 32'h4);
        check("t2b_tx0", txat(0), 32'h44);
        check("t2b_tx1", txat(1), 32'h55);

        // watchdog revokes a silent source 1, pending source 2 follows
        txlog.delete(); grantlog.delete();
        base = tocnt;
        nostb[1] = 1'b1;
        srcq[1].push_back(9'h1AA);
        drive();
        tick();
        check("t3_grant", 32'(o_grant), 32'h2);
        srcq[2].push_back(9'h1BB);
        drive();
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_timeout && n < 40);
        check("t3_timeout_lat", 32'(n), 32'd16);
        srcq[1].delete();
        nostb[1] = 1'b0;
        drive();
        tick();
        check("t3_grant_off", 32'(o_grant), 32'h0);
        check("t3_to_pulse", 32'(o_timeout), 32'h0);
        tick();
        check("t3_next_grant", 32'(o_grant), 32'h4);
        wait_idle("t3_done");
        check("t3_to_count", 32'(tocnt - base), 32'd1);
        check("t3_tx0", txat(0), 32'hBB);

        // source 2 aborts after its first byte with the next byte still offered
        txlog.delete(); grantlog.delete();
        base = ackcnt[2];
        srcq[2].push_back(9'h0C1); srcq[2].push_back(9'h1C2);
        drive();
        n = 0;
        while (ackcnt[2] == base && n < 40) begin
            tick();
            n++;
        end
        drop[2] = 1'b1;
        drive();
        n = 0;
        while (o_grant != 3'b000 && n < 60) begin
            tick();
            n++;
        end
        repeat (6) tick();
        check("t4_grant_off", 32'(o_grant), 32'h0);
        check("t4_tx_count", 32'(txlog.size()), 32'd1);
        check("t4_tx0", txat(0), 32'hC1);
        check("t4_acks", 32'(ackcnt[2] - base), 32'd1);
        srcq[2].delete();
        drop[2] = 1'b0;
        grantlog.delete();
        srcq[0].push_back(9'h1D0); srcq[1].push_back(9'h1D1);
        drive();
        wait_idle("t4_done");
        check("t4_rr_g0", gat(0), 32'h1);
        check("t4_rr_g1", gat(1), 32'h2);

        // transmitter busy before the first byte
        txlog.delete(); grantlog.delete();
        force_busy = 1'b1;
        srcq[0].push_back(9'h15A);
        drive();
        tick();
        check("t5_grant", 32'(o_grant), 32'h1);
        repeat (6) tick();
        check("t5_no_stb", 32'(txlog.size()), 32'd0);
        force_busy = 1'b0;
        drive();
        tick();
        check("t5_stb", 32'(o_tx_stb), 32'h1);
        check("t5_data", 32'(o_tx_data), 32'h5A);
        wait_idle("t5_done");

        // reset in the middle of a drain
        txlog.delete(); grantlog.delete();
        srcq[0].push_back(9'h166);
        drive();
        n = 0;
        while (!o_tx_stb && n < 40) begin
            tick();
            n++;
        end
        tick();
        check("t6_drain_grant", 32'(o_grant), 32'h1);
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_grant", 32'(o_grant), 32'h0);
        check("t6_rst_ack", 32'(o_ack), 32'h0);
        check("t6_rst_stb", 32'(o_tx_stb), 32'h0);
        check("t6_rst_timeout", 32'(o_timeout), 32'h0);
        for (int k = 0; k < NREQ; k++) srcq[k].delete();
        srcq[0].push_back(9'h177); srcq[2].push_back(9'h188);
        txlog.delete(); grantlog.delete();
        drive();
        repeat (2) tick();
        i_rst_n = 1'b1;
        drive();
        tick();
        check("t6_first_grant", 32'(o_grant), 32'h1);
        wait_idle("t6_done");
        check("t6_g0", gat(0), 32'h1);
        check("t6_g1", gat(1), 32'h4);
        check("t6_tx0", txat(0), 32'h77);
        check("t6_tx1", txat(1), 32'h88);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
